// File: rtl/fmap_pkg.sv
// ============================================================================
//  Module  : fmap_pkg
//  Purpose : Shared constants and types for the feature-map frame streamer:
//            default channel geometry, buffer FSM states and bank selector.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fmap_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CH_DEF         = 8;
  localparam int WORD_W_DEF     = DATA_WIDTH_DEF * CH_DEF;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic bank_sel_t;

  localparam bank_sel_t BANK_A = 1'b0;
  localparam bank_sel_t BANK_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fmap_frame_streamer_if.sv
// ============================================================================
//  Module  : fmap_frame_streamer_if
//  Purpose : Write-side stream, read pacing and replayed pixel stream of the
//            frame streamer, bundled as one interface.
//  Ports   : master modport drives wr_valid/wr_data/rd_stall and observes
//            o_data/o_valid/o_sof/o_eof/frame_ready/overflow; slave modport
//            is the mirror image used by the streamer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fmap_frame_streamer_if
  import fmap_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              rd_stall;
  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              o_sof;
  logic              o_eof;
  logic              frame_ready;
  logic              overflow;

  modport master (
    output wr_valid, wr_data, rd_stall,
    input  o_data, o_valid, o_sof, o_eof, frame_ready, overflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_stall,
    output o_data, o_valid, o_sof, o_eof, frame_ready, overflow
  );

endinterface

`default_nettype wire

// File: rtl/fmap_bank_ram.sv
// ============================================================================
//  Module  : fmap_bank_ram
//  Purpose : DEPTH x WORD_W simple dual-port frame RAM. One write port, one
//            synchronous read port with 1-cycle latency. The read register
//            holds its value when no read is issued.
//  Ports   : clk, rst (async, active-high, clears read register only)
//            we/waddr/wdata - write port
//            re/raddr/rdata - read port
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_bank_ram
  import fmap_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fmap_frame_streamer.sv
// ============================================================================
//  Module  : fmap_frame_streamer
//  Purpose : Inter-layer frame buffer. Collects one full feature map
//            (WIDTH*WIDTH words) and replays it in raster order as a
//            valid-qualified stream paced by rd_stall.
//  Ports   : clk, rst (async, active-high)
//            bus.wr_valid/wr_data  - incoming pixel words
//            bus.rd_stall          - suppress read issue this cycle
//            bus.o_data/o_valid    - replayed words, 1-cycle read latency
//            bus.o_sof/o_eof       - first/last word of frame markers
//            bus.frame_ready       - complete frame held and not fully read
//            bus.overflow          - sticky, a write was dropped
//  Config  : FMAP_PINGPONG_EN selects the two-bank ping-pong buffer;
//            undefined builds a single-bank buffer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_frame_streamer
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CH         = CH_DEF,
  parameter int WIDTH      = 56
) (
  input  logic                 clk,
  input  logic                 rst,
  fmap_frame_streamer_if.slave bus
);

  localparam int WORD_W = DATA_WIDTH * CH;
  localparam int DEPTH  = WIDTH * WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

  logic [AW-1:0]     r_wr_addr;
  logic [AW-1:0]     r_rd_addr;
  logic              r_valid;
  logic              r_sof;
  logic              r_eof;
  logic              r_overflow;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_drop;
  logic              w_frame_ready;
  logic [WORD_W-1:0] w_rd_data;

  logic w_wr_last;
  logic w_rd_last;
  assign w_wr_last = (r_wr_addr == C_LAST);
  assign w_rd_last = (r_rd_addr == C_LAST);

  // Pointers and output flags. DEPTH need not be a power of two, so the
  // pointers wrap explicitly at the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_addr <= w_wr_last ? '0 : r_wr_addr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_addr <= w_rd_last ? '0 : r_rd_addr + 1'b1;
      end
      r_valid <= w_rd_en;
      r_sof   <= w_rd_en && (r_rd_addr == '0);
      r_eof   <= w_rd_en && w_rd_last;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef FMAP_PINGPONG_EN
  // Banks fill and stream in strict alternation, so completion order equals
  // fill order and one toggle per pointer tracks which bank is next.
  bank_sel_t         r_fill_bank;
  bank_sel_t         r_stream_bank;
  bank_sel_t         r_rd_bank;
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic [WORD_W-1:0] w_bank_rdata [2];

  always_comb begin
    w_wr_en    = bus.wr_valid && !r_full[r_fill_bank];
    w_drop     = bus.wr_valid &&  r_full[r_fill_bank];
    w_rd_en    = r_full[r_stream_bank] && !bus.rd_stall;
    w_full_nxt = r_full;
    // The filling bank is never full and the streaming bank always is, so
    // these two updates can never target the same bank.
    if (w_wr_en && w_wr_last) begin
      w_full_nxt[r_fill_bank] = 1'b1;
    end
    if (w_rd_en && w_rd_last) begin
      w_full_nxt[r_stream_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full        <= '0;
      r_fill_bank   <= BANK_A;
      r_stream_bank <= BANK_A;
      r_rd_bank     <= BANK_A;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_en && w_wr_last) begin
        r_fill_bank <= ~r_fill_bank;
      end
      if (w_rd_en && w_rd_last) begin
        r_stream_bank <= ~r_stream_bank;
      end
      if (w_rd_en) begin
        r_rd_bank <= r_stream_bank;
      end
    end
  end

  assign w_frame_ready = |r_full;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank_ram #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wr_en && (r_fill_bank == bank_sel_t'(b))),
      .waddr (r_wr_addr),
      .wdata (bus.wr_data),
      .re    (w_rd_en && (r_stream_bank == bank_sel_t'(b))),
      .raddr (r_rd_addr),
      .rdata (w_bank_rdata[b])
    );
  end

  // Select by the bank of the most recent read so o_data holds between valids.
  assign w_rd_data = w_bank_rdata[r_rd_bank];
`else
  state_t r_state;
  state_t w_state_nxt;
  logic   r_frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      FILL: begin
        w_wr_en = bus.wr_valid;
        if (bus.wr_valid && w_wr_last) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        // Includes the final issue cycle: writes resume one cycle later.
        w_drop  = bus.wr_valid;
        w_rd_en = !bus.rd_stall;
        if (!bus.rd_stall && w_rd_last) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_ready <= 1'b0;
    end else if (w_wr_en && w_wr_last) begin
      r_frame_ready <= 1'b1;
    end else if (w_rd_en && w_rd_last) begin
      r_frame_ready <= 1'b0;
    end
  end

  assign w_frame_ready = r_frame_ready;

  fmap_bank_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_en),
    .waddr (r_wr_addr),
    .wdata (bus.wr_data),
    .re    (w_rd_en),
    .raddr (r_rd_addr),
    .rdata (w_rd_data)
  );
`endif

  assign bus.o_data      = w_rd_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_sof       = r_sof;
  assign bus.o_eof       = r_eof;
  assign bus.frame_ready = w_frame_ready;
  assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fmap_frame_streamer.sv
// ============================================================================
//  Module  : tb_fmap_frame_streamer
//  Purpose : Self-checking bench for fmap_frame_streamer with WIDTH=4
//            (16-word frames, word k = k in every channel). Expected output
//            words are queued as they are written and popped by a monitor.
//  Config  : FMAP_PINGPONG_EN selects the two-bank scenarios.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmap_frame_streamer;

  localparam int DW    = 32;
  localparam int CH    = 8;
  localparam int WIDTH = 4;
  localparam int DEPTH = WIDTH * WIDTH;
  localparam int WW    = DW * CH;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          sof;
    logic          eof;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  fmap_frame_streamer_if #(.WORD_W(WW)) bus ();

  fmap_frame_streamer #(
    .DATA_WIDTH (DW),
    .CH         (CH),
    .WIDTH      (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WW-1:0] word(input int k);
    return {CH{DW'(k)}};
  endfunction

  function automatic exp_t mk(input int k, input bit sof, input bit eof);
    exp_t e;
    e.data = word(k);
    e.sof  = sof;
    e.eof  = eof;
    return e;
  endfunction

  // Scoreboard consumer: every valid output word must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got data=%0h sof=%0b eof=%0b with nothing expected",
                 bus.o_data[DW-1:0], bus.o_sof, bus.o_eof);
      end else begin
        e = exp_q.pop_front();
        if ({bus.o_data, bus.o_sof, bus.o_eof} !== {e.data, e.sof, e.eof}) begin
          failures++;
          $display("FAIL out_word got data=%0h sof=%0b eof=%0b expected data=%0h sof=%0b eof=%0b",
                   bus.o_data, bus.o_sof, bus.o_eof, e.data, e.sof, e.eof);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b sof=%0b eof=%0b data=%0h expected all 0",
               bus.o_valid, bus.o_sof, bus.o_eof, bus.o_data);
    end
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_ready got %0b expected 0", bus.frame_ready);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow got %0b expected 0", bus.overflow);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got o_valid=%0b expected 0", bus.o_valid);
    end
  endtask

  task automatic test_basic();
    int cyc;
    int n_valid;
    int last_cyc;
    bus.rd_stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(k);
      exp_q.push_back(mk(k, k == 0, k == DEPTH - 1));
      if (k == DEPTH - 1) begin
        checks++;
        if (bus.frame_ready !== 1'b0) begin
          failures++;
          $display("FAIL basic_fr_before_full got %0b expected 0", bus.frame_ready);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_fr_after_full got %0b expected 1", bus.frame_ready);
    end
    cyc = 0;
    n_valid = 0;
    last_cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_valid) begin
        n_valid++;
        last_cyc = cyc;
      end
      if (bus.o_valid && bus.o_eof) begin
        checks++;
        if (bus.frame_ready !== 1'b0) begin
          failures++;
          $display("FAIL basic_fr_fall got %0b expected 0 at eof", bus.frame_ready);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain got %0d words left expected 0", exp_q.size());
    end
    checks++;
    if (n_valid != DEPTH || last_cyc != DEPTH) begin
      failures++;
      $display("FAIL basic_back_to_back got %0d valids ending cycle %0d expected %0d ending cycle %0d",
               n_valid, last_cyc, DEPTH, DEPTH);
    end
  endtask

  task automatic test_random_stall();
    int  iters;
    int  stalls;
    int  got;
    bit  st;
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(k);
      bus.rd_stall = 1'($urandom_range(0, 1));
      exp_q.push_back(mk(k, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
      checks++;
      if (bus.o_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_fill_quiet got o_valid=%0b expected 0", bus.o_valid);
      end
    end
    bus.wr_valid = 1'b0;
    iters = 0;
    stalls = 0;
    got = 0;
    while (got < DEPTH && iters < 200) begin
      st = ($urandom_range(0, 99) < 40);
      bus.rd_stall = st;
      iters++;
      if (st) stalls++;
      @(posedge clk);
      #1;
      checks++;
      if (bus.o_valid !== !st) begin
        failures++;
        $display("FAIL stall_gap got o_valid=%0b expected %0b (stall=%0b)", bus.o_valid, !st, st);
      end
      if (bus.o_valid) got++;
    end
    bus.rd_stall = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (got != DEPTH || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_count got %0d valids, %0d left expected %0d, 0", got, exp_q.size(), DEPTH);
    end
    checks++;
    if (iters + 1 != DEPTH + stalls + 1) begin
      failures++;
      $display("FAIL stall_total_cycles got %0d expected %0d", iters + 1, DEPTH + stalls + 1);
    end
  endtask

`ifndef FMAP_PINGPONG_EN
  task automatic test_overflow();
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_initial got %0b expected 0", bus.overflow);
    end
    bus.rd_stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(20 + k);
      exp_q.push_back(mk(20 + k, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(900 + i);
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_drain got %0d words left expected 0", exp_q.size());
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got %0b expected 1", bus.overflow);
    end
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(40 + k);
      exp_q.push_back(mk(40 + k, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_next_drain got %0d words left expected 0", exp_q.size());
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got %0b expected 1", bus.overflow);
    end
  endtask
`else
  task automatic test_pingpong();
    bus.rd_stall = 1'b0;
    for (int j = 1; j <= 2 * DEPTH; j++) begin
      int v;
      int k;
      k = (j - 1) % DEPTH;
      v = (j <= DEPTH) ? k : 100 + k;
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(v);
      exp_q.push_back(mk(v, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
      if (j >= DEPTH + 1) begin
        checks++;
        if (bus.o_valid !== 1'b1) begin
          failures++;
          $display("FAIL pp_stream_a got o_valid=%0b expected 1 after write %0d", bus.o_valid, j);
        end
      end
    end
    bus.wr_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_sof !== 1'b1) begin
      failures++;
      $display("FAIL pp_no_idle got valid=%0b sof=%0b expected 1 1", bus.o_valid, bus.o_sof);
    end
    bus.rd_stall = 1'b1;
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL pp_no_overflow got %0b expected 0", bus.overflow);
    end
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(200 + k);
      exp_q.push_back(mk(200 + k, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL pp_third_fill got overflow=%0b frame_ready=%0b expected 0 1",
               bus.overflow, bus.frame_ready);
    end
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(300 + i);
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL pp_overflow got %0b expected 1", bus.overflow);
    end
    bus.rd_stall = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pp_drain got %0d words left expected 0", exp_q.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    int cyc;
    bus.rd_stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(60 + k);
      exp_q.push_back(mk(60 + k, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    seen = 0;
    cyc = 0;
    while (seen < 7 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_valid) seen++;
    end
    checks++;
    if (seen != 7) begin
      failures++;
      $display("FAIL rstmid_reach got %0d words expected 7", seen);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_sof, bus.o_eof, bus.frame_ready, bus.overflow, bus.o_data} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got valid=%0b sof=%0b eof=%0b fr=%0b ovf=%0b data=%0h expected all 0",
               bus.o_valid, bus.o_sof, bus.o_eof, bus.frame_ready, bus.overflow, bus.o_data);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = word(k);
      exp_q.push_back(mk(k, k == 0, k == DEPTH - 1));
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_refill got %0d words left expected 0", exp_q.size());
    end
  endtask

  task automatic test_gapped_fill();
    int k;
    int cyc;
    bus.rd_stall = 1'b0;
    k = 0;
    cyc = 0;
    while (k < DEPTH && cyc < 200) begin
      cyc++;
      if ($urandom_range(0, 1) == 1) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = word(k);
        exp_q.push_back(mk(k, k == 0, k == DEPTH - 1));
        k++;
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = word(777);
      end
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL gap_drain got %0d words left expected 0", exp_q.size());
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL gap_overflow got %0b expected 0", bus.overflow);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_stall = 1'b0;
    test_reset();
    test_basic();
    test_random_stall();
`ifndef FMAP_PINGPONG_EN
    test_overflow();
`else
    test_pingpong();
`endif
    test_reset_mid();
    test_gapped_fill();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
